// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: latches decoded fields, builds forwarded ALU operands,
// and raises a load-use stall that turns the next latch into a bubble.
package id_ex_operand_stage_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

// One source operand (rs or rt): write-back bypass at capture time and
// EX/MEM > MEM/WB forwarding on the latched value. Register 0 never forwards.
module id_ex_src_lane #(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_dec_sel,
    input  logic [DW-1:0] i_dec_rdat,
    input  logic [RW-1:0] i_lat_sel,
    input  logic [DW-1:0] i_lat_rdat,
    input  logic          i_exmem_regwen,
    input  logic [RW-1:0] i_exmem_wsel,
    input  logic [DW-1:0] i_exmem_wdat,
    input  logic          i_memwb_regwen,
    input  logic [RW-1:0] i_memwb_wsel,
    input  logic [DW-1:0] i_memwb_wdat,
    output logic [DW-1:0] o_cap_rdat,
    output logic [DW-1:0] o_fwd_rdat
);
    logic w_cap_hit;
    logic w_ex_hit;
    logic w_wb_hit;
    logic w_lat_nz;

    assign w_cap_hit = i_memwb_regwen && (i_memwb_wsel != '0) && (i_memwb_wsel == i_dec_sel);
    assign o_cap_rdat = w_cap_hit ? i_memwb_wdat : i_dec_rdat;

    assign w_lat_nz = (i_lat_sel != '0);
    assign w_ex_hit = w_lat_nz && i_exmem_regwen && (i_exmem_wsel == i_lat_sel);
    assign w_wb_hit = w_lat_nz && i_memwb_regwen && (i_memwb_wsel == i_lat_sel);

    always_comb begin
        o_fwd_rdat = i_lat_rdat;
        if (w_ex_hit)
            o_fwd_rdat = i_exmem_wdat;
        else if (w_wb_hit)
            o_fwd_rdat = i_memwb_wdat;
    end
endmodule

module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          dec_valid,
    input  aluop_t        dec_aluop,
    input  logic [RW-1:0] dec_rs,
    input  logic [RW-1:0] dec_rt,
    input  logic [RW-1:0] dec_wsel,
    input  logic [DW-1:0] dec_rdat1,
    input  logic [DW-1:0] dec_rdat2,
    input  logic [DW-1:0] dec_imm,
    input  logic [4:0]    dec_shamt,
    input  logic [1:0]    dec_alusrc,
    input  logic          dec_regwen,
    input  logic          dec_memread,
    input  logic          flush,
    input  logic          exmem_regwen,
    input  logic [RW-1:0] exmem_wsel,
    input  logic [DW-1:0] exmem_wdat,
    input  logic          memwb_regwen,
    input  logic [RW-1:0] memwb_wsel,
    input  logic [DW-1:0] memwb_wdat,
    output logic          stall,
    output logic          ex_valid,
    output aluop_t        ex_aluop,
    output logic [RW-1:0] ex_wsel,
    output logic          ex_regwen,
    output logic          ex_memread,
    output logic [DW-1:0] Port_A,
    output logic [DW-1:0] Port_B,
    output logic [DW-1:0] ex_store_data
);
    localparam int NSRC = 2;

    logic          r_valid;
    aluop_t        r_aluop;
    logic [RW-1:0] r_rs;
    logic [RW-1:0] r_rt;
    logic [RW-1:0] r_wsel;
    logic [DW-1:0] r_rdat1;
    logic [DW-1:0] r_rdat2;
    logic [DW-1:0] r_imm;
    logic [4:0]    r_shamt;
    logic [1:0]    r_alusrc;
    logic          r_regwen;
    logic          r_memread;

    // Lane 0 is rs, lane 1 is rt.
    logic [NSRC-1:0][RW-1:0] w_dec_sel;
    logic [NSRC-1:0][DW-1:0] w_dec_rdat;
    logic [NSRC-1:0][RW-1:0] w_lat_sel;
    logic [NSRC-1:0][DW-1:0] w_lat_rdat;
    logic [NSRC-1:0][DW-1:0] w_cap_rdat;
    logic [NSRC-1:0][DW-1:0] w_fwd_rdat;
    logic                    w_bubble;

    assign w_dec_sel  = {dec_rt, dec_rs};
    assign w_dec_rdat = {dec_rdat2, dec_rdat1};
    assign w_lat_sel  = {r_rt, r_rs};
    assign w_lat_rdat = {r_rdat2, r_rdat1};

    genvar g;
    generate
        for (g = 0; g < NSRC; g++) begin : g_src
            id_ex_src_lane #(.DW(DW), .RW(RW)) u_lane (
                .i_dec_sel      (w_dec_sel[g]),
                .i_dec_rdat     (w_dec_rdat[g]),
                .i_lat_sel      (w_lat_sel[g]),
                .i_lat_rdat     (w_lat_rdat[g]),
                .i_exmem_regwen (exmem_regwen),
                .i_exmem_wsel   (exmem_wsel),
                .i_exmem_wdat   (exmem_wdat),
                .i_memwb_regwen (memwb_regwen),
                .i_memwb_wsel   (memwb_wsel),
                .i_memwb_wdat   (memwb_wdat),
                .o_cap_rdat     (w_cap_rdat[g]),
                .o_fwd_rdat     (w_fwd_rdat[g])
            );
        end
    endgenerate

    // rt is compared even when the decoded op uses an immediate: cheaper than
    // decoding operand usage and only costs an occasional extra bubble.
    assign stall = r_valid && r_memread && (r_wsel != '0) && dec_valid &&
                   ((r_wsel == dec_rs) || (r_wsel == dec_rt));

    assign w_bubble = RST || flush || stall;

    always_ff @(posedge CLK) begin
        if (w_bubble) begin
            r_valid   <= 1'b0;
            r_aluop   <= ALU_SLL;
            r_rs      <= '0;
            r_rt      <= '0;
            r_wsel    <= '0;
            r_rdat1   <= '0;
            r_rdat2   <= '0;
            r_imm     <= '0;
            r_shamt   <= '0;
            r_alusrc  <= '0;
            r_regwen  <= 1'b0;
            r_memread <= 1'b0;
        end else begin
            r_valid   <= dec_valid;
            r_aluop   <= dec_aluop;
            r_rs      <= dec_rs;
            r_rt      <= dec_rt;
            r_wsel    <= dec_wsel;
            r_rdat1   <= w_cap_rdat[0];
            r_rdat2   <= w_cap_rdat[1];
            r_imm     <= dec_imm;
            r_shamt   <= dec_shamt;
            r_alusrc  <= dec_alusrc;
            r_regwen  <= dec_regwen;
            r_memread <= dec_memread;
        end
    end

    always_comb begin
        Port_B = '0;
        case (r_alusrc)
            2'd0:    Port_B = w_fwd_rdat[1];
            2'd1:    Port_B = r_imm;
            2'd2:    Port_B = {{(DW-5){1'b0}}, r_shamt};
            default: Port_B = '0;
        endcase
    end

    assign Port_A        = w_fwd_rdat[0];
    assign ex_store_data = w_fwd_rdat[1];
    assign ex_valid      = r_valid;
    assign ex_aluop      = r_aluop;
    assign ex_wsel       = r_wsel;
    assign ex_regwen     = r_regwen;
    assign ex_memread    = r_memread;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for id_ex_operand_stage: stimulus pushes expectations into a
// queue, a separate monitor drains and compares them on each sample strobe.
module tb_id_ex_operand_stage;
    import id_ex_operand_stage_pkg::*;

    localparam int K_VALID = 0, K_A = 1, K_B = 2, K_STALL = 3, K_REGWEN = 4,
                   K_OP = 5, K_STORE = 6, K_WSEL = 7;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic        dec_valid;
    aluop_t      dec_aluop;
    logic [4:0]  dec_rs, dec_rt, dec_wsel;
    logic [31:0] dec_rdat1, dec_rdat2, dec_imm;
    logic [4:0]  dec_shamt;
    logic [1:0]  dec_alusrc;
    logic        dec_regwen, dec_memread, flush;
    logic        exmem_regwen, memwb_regwen;
    logic [4:0]  exmem_wsel, memwb_wsel;
    logic [31:0] exmem_wdat, memwb_wdat;
    logic        stall, ex_valid, ex_regwen, ex_memread;
    aluop_t      ex_aluop;
    logic [4:0]  ex_wsel;
    logic [31:0] Port_A, Port_B, ex_store_data;

    exp_t q[$];
    event sample_ev;
    int   n_chk  = 0;
    int   n_fail = 0;

    id_ex_operand_stage #(.DW(32), .RW(5)) dut (
        .CLK(CLK), .RST(RST), .dec_valid(dec_valid), .dec_aluop(dec_aluop),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_wsel(dec_wsel),
        .dec_rdat1(dec_rdat1), .dec_rdat2(dec_rdat2), .dec_imm(dec_imm),
        .dec_shamt(dec_shamt), .dec_alusrc(dec_alusrc), .dec_regwen(dec_regwen),
        .dec_memread(dec_memread), .flush(flush),
        .exmem_regwen(exmem_regwen), .exmem_wsel(exmem_wsel), .exmem_wdat(exmem_wdat),
        .memwb_regwen(memwb_regwen), .memwb_wsel(memwb_wsel), .memwb_wdat(memwb_wdat),
        .stall(stall), .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_wsel(ex_wsel),
        .ex_regwen(ex_regwen), .ex_memread(ex_memread),
        .Port_A(Port_A), .Port_B(Port_B), .ex_store_data(ex_store_data)
    );

    always #5 CLK = ~CLK;

    // Monitor: drains every pending expectation on each sample strobe.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                case (e.kind)
                    K_VALID:  act = {31'b0, ex_valid};
                    K_A:      act = Port_A;
                    K_B:      act = Port_B;
                    K_STALL:  act = {31'b0, stall};
                    K_REGWEN: act = {31'b0, ex_regwen};
                    K_OP:     act = 32'(ex_aluop);
                    K_STORE:  act = ex_store_data;
                    default:  act = {27'b0, ex_wsel};
                endcase
                n_chk++;
                if (act !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic expect_v(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = k; e.val = v;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk();
        #1;
        ->sample_ev;
        #1;
    endtask

    task automatic set_dec(input logic v, input aluop_t op, input logic [4:0] rs,
                           input logic [4:0] rt, input logic [4:0] ws,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic [31:0] im, input logic [4:0] sh,
                           input logic [1:0] src, input logic rw, input logic mr);
        dec_valid = v; dec_aluop = op; dec_rs = rs; dec_rt = rt; dec_wsel = ws;
        dec_rdat1 = d1; dec_rdat2 = d2; dec_imm = im; dec_shamt = sh;
        dec_alusrc = src; dec_regwen = rw; dec_memread = mr;
    endtask

    task automatic clr_fwd();
        exmem_regwen = 0; exmem_wsel = 0; exmem_wdat = 0;
        memwb_regwen = 0; memwb_wsel = 0; memwb_wdat = 0;
    endtask

    initial begin
        RST = 1; flush = 0;
        clr_fwd();
        set_dec(1, ALU_ADD, 5'd1, 5'd2, 5'd3, 32'd10, 32'd15, 32'd0, 5'd0, 2'd0, 1, 0);

        // Reset held two edges with a valid decode slot
        tick(); tick();
        expect_v("rst_valid", K_VALID, 0);
        expect_v("rst_port_a", K_A, 0);
        expect_v("rst_port_b", K_B, 0);
        expect_v("rst_stall", K_STALL, 0);
        expect_v("rst_aluop", K_OP, 32'(ALU_SLL));
        expect_v("rst_regwen", K_REGWEN, 0);
        expect_v("rst_store", K_STORE, 0);
        chk();

        // Plain ADD capture
        RST = 0;
        tick();
        dec_valid = 0;
        expect_v("cap_valid", K_VALID, 1);
        expect_v("cap_port_a", K_A, 32'd10);
        expect_v("cap_port_b", K_B, 32'd15);
        expect_v("cap_aluop", K_OP, 32'(ALU_ADD));
        expect_v("cap_regwen", K_REGWEN, 1);
        expect_v("cap_wsel", K_WSEL, 32'd3);
        chk();

        // Forward priority on latched rs=3
        set_dec(1, ALU_ADD, 5'd3, 5'd0, 5'd6, 32'h1111, 32'd0, 32'd0, 5'd0, 2'd0, 1, 0);
        tick();
        dec_valid = 0; dec_rs = 0;
        exmem_regwen = 1; exmem_wsel = 3; exmem_wdat = 32'hAAAA0000;
        memwb_regwen = 1; memwb_wsel = 3; memwb_wdat = 32'h5555;
        expect_v("fwd_exmem_wins", K_A, 32'hAAAA0000);
        chk();
        exmem_regwen = 0;
        expect_v("fwd_memwb", K_A, 32'h5555);
        chk();
        exmem_regwen = 1; exmem_wsel = 0; memwb_wsel = 0;
        expect_v("fwd_none_latched", K_A, 32'h1111);
        chk();
        clr_fwd();

        // Load-use: LW r4, then SUB using r4
        set_dec(1, ALU_ADD, 5'd0, 5'd0, 5'd4, 32'd0, 32'd0, 32'h10, 5'd0, 2'd1, 1, 1);
        tick();
        set_dec(1, ALU_SUB, 5'd4, 5'd7, 5'd5, 32'hDEAD, 32'h22, 32'd0, 5'd0, 2'd0, 1, 0);
        expect_v("lu_stall", K_STALL, 1);
        expect_v("lu_lw_valid", K_VALID, 1);
        expect_v("lu_lw_port_b_imm", K_B, 32'h10);
        chk();
        tick();
        memwb_regwen = 1; memwb_wsel = 4; memwb_wdat = 32'hCAFE0004;
        expect_v("lu_bubble_valid", K_VALID, 0);
        expect_v("lu_bubble_regwen", K_REGWEN, 0);
        expect_v("lu_bubble_stall", K_STALL, 0);
        chk();
        tick();
        clr_fwd();
        dec_valid = 0;
        expect_v("lu_sub_valid", K_VALID, 1);
        expect_v("lu_sub_port_a_bypass", K_A, 32'hCAFE0004);
        expect_v("lu_sub_port_b", K_B, 32'h22);
        expect_v("lu_sub_aluop", K_OP, 32'(ALU_SUB));
        chk();

        // Flush during a load-use cycle
        set_dec(1, ALU_ADD, 5'd0, 5'd0, 5'd8, 32'd0, 32'd0, 32'd0, 5'd0, 2'd1, 1, 1);
        tick();
        set_dec(1, ALU_OR, 5'd8, 5'd0, 5'd9, 32'h77, 32'd0, 32'd0, 5'd0, 2'd0, 1, 0);
        flush = 1;
        expect_v("fl_stall_indep", K_STALL, 1);
        chk();
        tick();
        flush = 0; dec_valid = 0;
        expect_v("fl_bubble_valid", K_VALID, 0);
        expect_v("fl_bubble_regwen", K_REGWEN, 0);
        chk();
        tick();
        expect_v("fl_never_valid", K_VALID, 0);
        chk();

        // Operand select: shamt, imm, reserved
        set_dec(1, ALU_SLL, 5'd5, 5'd0, 5'd10, 32'd1, 32'd0, 32'd0, 5'd5, 2'd2, 1, 0);
        tick();
        set_dec(1, ALU_OR, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'h0000000F, 5'd0, 2'd1, 1, 0);
        expect_v("sel_sll_valid", K_VALID, 1);
        expect_v("sel_sll_port_a", K_A, 32'd1);
        expect_v("sel_shamt", K_B, 32'd5);
        chk();
        tick();
        set_dec(1, ALU_ADD, 5'd0, 5'd2, 5'd12, 32'd0, 32'h99, 32'h1234, 5'd3, 2'd3, 1, 0);
        expect_v("sel_imm", K_B, 32'h0000000F);
        expect_v("sel_ori_aluop", K_OP, 32'(ALU_OR));
        chk();
        tick();
        dec_valid = 0;
        expect_v("sel_reserved", K_B, 32'd0);
        expect_v("sel_store_latched", K_STORE, 32'h99);
        chk();
        exmem_regwen = 1; exmem_wsel = 2; exmem_wdat = 32'h3333;
        expect_v("sel_store_fwd", K_STORE, 32'h3333);
        expect_v("sel_reserved_fwd", K_B, 32'd0);
        chk();
        clr_fwd();

        // Reset asserted mid-stream
        set_dec(1, ALU_ADD, 5'd1, 5'd0, 5'd3, 32'd5, 32'd0, 32'd0, 5'd0, 2'd0, 1, 0);
        tick();
        expect_v("mid_pre_valid", K_VALID, 1);
        chk();
        RST = 1;
        tick();
        RST = 0;
        expect_v("mid_rst_valid", K_VALID, 0);
        expect_v("mid_rst_port_a", K_A, 0);
        chk();

        // Flush without hazard
        tick();
        expect_v("flush_pre_valid", K_VALID, 1);
        chk();
        flush = 1;
        tick();
        flush = 0;
        expect_v("flush_only_valid", K_VALID, 0);
        chk();

        #2;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline stage that sits directly upstream of the `alu`. It latches decoded instruction fields and builds the ALU's `Port_A`/`Port_B` with EX/MEM and MEM/WB forwarding. It detects load-use hazards, inserts bubbles on stall or flush, and passes destination and control bits down to EX/MEM.

## Interface
Parameters:
- `DW`, 32, datapath width
- `RW`, 5, register-select width

Ports (clock and reset first):
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, synchronous, active-high
- `dec_valid`  in  1  decode slot holds a real instruction
- `dec_aluop`  in  aluop_t  ALU operation
- `dec_rs`, `dec_rt`  in  RW  source register selects
- `dec_wsel`  in  RW  destination register
- `dec_rdat1`, `dec_rdat2`  in  DW  register file read data
- `dec_imm`  in  DW  immediate, already extended
- `dec_shamt`  in  5  shift amount
- `dec_alusrc`  in  2  Port_B select: 0 rt, 1 imm, 2 shamt, 3 reserved
- `dec_regwen`, `dec_memread`  in  1  write-back enable; instruction is a load
- `flush`  in  1  squash decode slot (branch/jump redirect)
- `exmem_regwen`, `exmem_wsel`, `exmem_wdat`  in  1/RW/DW  EX/MEM forward source
- `memwb_regwen`, `memwb_wsel`, `memwb_wdat`  in  1/RW/DW  MEM/WB forward source
- `stall`  out  1  load-use hazard; decode/fetch must hold
- `ex_valid`, `ex_aluop`, `ex_wsel`, `ex_regwen`, `ex_memread`  out  registered fields to EX
- `Port_A`, `Port_B`  out  DW  ALU operands
- `ex_store_data`  out  DW  forwarded rt value, for stores

## Operation
- Registered state: valid, aluop, rs, rt, wsel, rdat1, rdat2, imm, shamt, alusrc, regwen, memread.
- At each rising edge, priority is:
  - `RST`: load a bubble.
  - Else `flush` or `stall`: load a bubble.
  - Else: capture the `dec_*` fields.
- Bubble contents: valid=0, regwen=0, memread=0, aluop=ALU_SLL, rs=rt=wsel=0, data fields=0.
- Capture bypass: if `memwb_regwen` and `memwb_wsel`≠0 and `memwb_wsel`==`dec_rs`, capture `memwb_wdat` into rdat1 instead of `dec_rdat1`. The same rule applies to rt/rdat2.
- Forwarding, evaluated per source (rs or rt):
  - Register 0 is never forwarded.
  - If `exmem_regwen` and `exmem_wsel`==src, use `exmem_wdat`.
  - Else if `memwb_regwen` and `memwb_wsel`==src, use `memwb_wdat`.
  - Else use the latched value.
  - EX/MEM always wins over MEM/WB.
- `Port_A` is the forwarded rs value.
- `Port_B` by latched alusrc:
  - 0: forwarded rt
  - 1: imm
  - 2: {27'b0, shamt}
  - 3: 0
- `ex_store_data` is always the forwarded rt value.
- `stall` = `ex_valid` & `ex_memread` & `ex_wsel`≠0 & `dec_valid` & (`ex_wsel`==`dec_rs` | `ex_wsel`==`dec_rt`).
  - rt is compared regardless of `dec_alusrc` (conservative).
- `stall` does not depend on `flush`. The upstream hazard unit gives flush priority. Both cases load a bubble here.

## Timing
- All `ex_*` fields change only at a rising edge, one cycle after capture.
- `Port_A`, `Port_B`, `ex_store_data` and `stall` are combinational from the latch and the forward/decode inputs, and valid within the same cycle.
- Reset values: all `ex_*` = 0, `ex_aluop`=ALU_SLL, `stall`=0 (latch invalid). `Port_A`/`Port_B`/`ex_store_data` are 0 unless forwarded; register 0 is never forwarded, so they are 0 after reset.
- Load-use costs exactly one bubble. On the next cycle the load is in EX/MEM, and its data is forwarded from MEM/WB one cycle later through the capture bypass or the forward path.
- `RST` asserted mid-stream: the next edge yields a bubble regardless of `flush`/`stall`/`dec_valid`.
- Back-to-back stalls are not possible after a bubble: `ex_valid`=0 forces `stall`=0.

## Test plan
- **Reset:** hold `RST` 2 cycles with `dec_valid`=1. Required: `ex_valid`=0, `Port_A`=`Port_B`=0, `stall`=0.
- **Plain capture:** ADD, rs=1 (rdat1=10), rt=2 (rdat2=15), alusrc=0, no forwarding. One edge later: `Port_A`=10, `Port_B`=15, `ex_aluop`=ALU_ADD, `ex_valid`=1.
- **Forward priority:** latched rs=3. Drive `exmem_wsel`=3/`exmem_wdat`=0xAAAA0000 and `memwb_wsel`=3/`memwb_wdat`=0x5555. Required: `Port_A`=0xAAAA0000. Drop `exmem_regwen`: `Port_A`=0x5555. Set wsel=0 on both: the latched value is used.
- **Load-use:** LW to wsel=4 in latch; decode SUB with rs=4.
  - Required: `stall`=1 in that cycle and a bubble next edge (`ex_valid`=0).
  - Decode is then held and captured next cycle with `memwb_wdat` bypass: `Port_A`=loaded value.
- **Flush vs stall:** assert `flush` during a load-use cycle. Required: bubble next edge, `ex_regwen`=0, and the flushed instruction never appears on `ex_valid`.
- **Operand select:** SLL with rs=5 (value 1), alusrc=2, shamt=5 gives `Port_B`=5. ORI with imm=0x0000000F, alusrc=1 gives `Port_B`=0x0000000F. alusrc=3 gives `Port_B`=0.
